// File: rtl/mem_stage_lsu.sv
// RV32I memory-stage load/store unit: turns the EX/MEM record into a bus access
// (byte/half/word, ready handshake, timeout) and produces the MEM/WB record.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_val,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    logic [0:0]  state_r;
    logic [7:0]  cnt_r;
    logic [1:0]  off_r;
    logic [2:0]  f3_r;
    logic [4:0]  rd_r;
    logic        regw_r;

    logic        is_mem_s;
    logic        illegal_s;
    logic        misalign_s;
    logic        start_s;
    logic        timeout_hit_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Width/alignment decode of the op presented in IDLE; illegal width outranks misalignment.
    always_comb begin
        is_mem_s = ex_valid & (ex_mem_read | ex_mem_write);
        case (ex_funct3)
            3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
            3'b100, 3'b101:         illegal_s = ~ex_mem_read;
            default:                illegal_s = 1'b1;
        endcase
        case (ex_funct3[1:0])
            2'b01:   misalign_s = ex_alu_result[0];
            2'b10:   misalign_s = |ex_alu_result[1:0];
            default: misalign_s = 1'b0;
        endcase
        start_s       = (state_r == ST_IDLE) & is_mem_s & ~illegal_s & ~misalign_s;
        timeout_hit_s = (state_r == ST_ACCESS) & (cnt_r == TO_LAST);
    end

    // Store lane steering: replicate data across lanes, strobe selects the target bytes.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                wstrb_s = 4'b0001 << ex_alu_result[1:0];
                wdata_s = {4{ex_rs2_val[7:0]}};
            end
            2'b01: begin
                wstrb_s = 4'b0011 << {ex_alu_result[1], 1'b0};
                wdata_s = {2{ex_rs2_val[15:0]}};
            end
            default: begin
                wstrb_s = 4'b1111;
                wdata_s = ex_rs2_val;
            end
        endcase
    end

    // Upstream stall; held low while reset is asserted.
    always_comb begin
        if (!reset) begin
            mem_stall = 1'b0;
        end else if (state_r == ST_IDLE) begin
            mem_stall = start_s;
        end else begin
            mem_stall = ~dmem_ready & ~timeout_hit_s;
        end
    end

    // Access FSM, bus request registers and writeback record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            off_r        <= 2'd0;
            f3_r         <= 3'd0;
            rd_r         <= 5'd0;
            regw_r       <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_wstrb   <= 4'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            wb_exc       <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wb_rd <= ex_rd;
                    if (start_s) begin
                        state_r      <= ST_ACCESS;
                        cnt_r        <= 8'd0;
                        off_r        <= ex_alu_result[1:0];
                        f3_r         <= ex_funct3;
                        rd_r         <= ex_rd;
                        regw_r       <= ex_reg_write & ex_mem_read;
                        dmem_req     <= 1'b1;
                        dmem_we      <= ex_mem_write;
                        dmem_addr    <= {ex_alu_result[31:2], 2'b00};
                        dmem_wdata   <= wdata_s;
                        dmem_wstrb   <= ex_mem_write ? wstrb_s : 4'b0000;
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                        wb_data      <= 32'd0;
                        wb_exc       <= 2'b00;
                    end else if (is_mem_s) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                        wb_data      <= 32'd0;
                        wb_exc       <= illegal_s ? 2'b11 : 2'b01;
                    end else if (ex_valid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= ex_reg_write;
                        wb_data      <= ex_alu_result;
                        wb_exc       <= 2'b00;
                    end else begin
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                        wb_data      <= 32'd0;
                        wb_exc       <= 2'b00;
                    end
                end
                ST_ACCESS: begin
                    cnt_r <= cnt_r + 8'd1;
                    wb_rd <= rd_r;
                    if (dmem_ready) begin
                        state_r      <= ST_IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_exc       <= 2'b00;
                        wb_reg_write <= regw_r;
                        wb_data      <= dmem_we ? 32'd0 : fmt_load(f3_r, off_r, dmem_rdata);
                    end else if (timeout_hit_s) begin
                        state_r      <= ST_IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_exc       <= 2'b10;
                        wb_reg_write <= 1'b0;
                        wb_data      <= 32'd0;
                    end else begin
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dmem_req <= 1'b0;
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit for the RV32I 5-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. It takes the EX/MEM result, performs byte/half/word loads and stores over a ready-handshaked data-memory port, and produces the writeback record. Non-memory instructions pass through. It stalls the upstream pipeline while a memory access is outstanding and reports misaligned, illegal-width and timeout exceptions.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of cycles with dmem_req high before the access is aborted; range 1..255.
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ex_valid  input  1  the EX/MEM slot holds a real instruction.
- ex_mem_read  input  1  load instruction.
- ex_mem_write  input  1  store instruction; ex_mem_read and ex_mem_write are never both high.
- ex_funct3  input  3  access width and sign, as in RV32I.
- ex_alu_result  input  32  effective address for memory ops, result for others.
- ex_rs2_val  input  32  store data.
- ex_rd  input  5  destination register.
- ex_reg_write  input  1  the instruction writes rd.
- mem_stall  output  1  combinational; upstream holds every ex_* input stable while high.
- dmem_req  output  1  registered; bus request.
- dmem_we  output  1  registered; 1 = store.
- dmem_addr  output  32  registered; word address, {ex_alu_result[31:2], 2'b00}.
- dmem_wdata  output  32  registered; lane-replicated store data.
- dmem_wstrb  output  4  registered; byte enables, 0000 for loads.
- dmem_ready  input  1  access complete in this cycle.
- dmem_rdata  input  32  load data, valid when dmem_ready is high.
- wb_valid  output  1  registered; one-cycle pulse per retired instruction.
- wb_rd  output  5  registered.
- wb_reg_write  output  1  registered; forced to 0 when wb_exc is non-zero.
- wb_data  output  32  registered; load result, ALU result, or 0 for stores and exceptions.
- wb_exc  output  2  registered; 00 none, 01 misaligned, 10 timeout, 11 illegal width.

## Operation
- State machine: IDLE and ACCESS.
- In IDLE, the input is a memory op when ex_valid is high and either ex_mem_read or ex_mem_write is high.
- Width decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other value is illegal.
  - Stores: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Alignment: halfword accesses need addr[0]=0; word accesses need addr[1:0]=00. An illegal width takes priority over a misalignment.
- IDLE, memory op, legal and aligned:
  - Assert mem_stall.
  - At the edge, load the dmem_* registers, set dmem_req=1, clear the timeout counter, and go to ACCESS.
- IDLE, memory op, illegal or misaligned:
  - No bus request and no stall.
  - At the edge: wb_valid=1, wb_exc=11 or 01, wb_reg_write=0, wb_data=0.
- IDLE, non-memory op with ex_valid high: at the edge, wb_valid=1, wb_data=ex_alu_result, and wb_rd and wb_reg_write are copied from the inputs.
- IDLE, ex_valid low: at the edge, wb_valid=0 and wb_reg_write=0.
- ACCESS:
  - dmem_* outputs are held stable.
  - mem_stall = ~dmem_ready & ~timeout_hit.
  - timeout_hit is high when the counter equals TIMEOUT_CYCLES-1. The counter increments each ACCESS cycle.
- ACCESS with dmem_ready high:
  - At the edge, dmem_req=0, state goes to IDLE, and wb_valid=1 with wb_exc=00.
  - A load writes the formatted dmem_rdata. A store gives wb_data=0 and wb_reg_write=0.
- ACCESS with timeout_hit high and dmem_ready low: at the edge, dmem_req=0, state goes to IDLE, wb_valid=1, wb_exc=10, wb_reg_write=0.
- Simultaneous dmem_ready and timeout_hit: dmem_ready wins.
- Store formatting:
  - SB: wstrb = 0001 << addr[1:0]; wdata = four copies of rs2[7:0].
  - SH: wstrb = 0011 << {addr[1],1'b0}; wdata = two copies of rs2[15:0].
  - SW: wstrb = 1111; wdata = rs2.
- Load formatting: select the byte or halfword lane of dmem_rdata using addr[1:0]. LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
- The module keeps the address offset, funct3, rd and reg_write it needs from the access-start cycle in its own registers.

## Timing
- Reset:
  - All outputs and the counter go to 0 and the state goes to IDLE, asynchronously.
  - mem_stall is also forced to 0 during reset.
  - A reset during ACCESS drops dmem_req immediately and the aborted op never produces a wb_valid.
- Non-memory op, or excepted op in IDLE: wb_valid one cycle after the op is presented, with no stall.
- Memory op presented in cycle C0:
  - dmem_req is high from C1.
  - If dmem_ready is high in cycle Cn (n≥1), wb_valid is high in Cn+1.
  - mem_stall is high in C0..Cn-1 and low in Cn, so upstream advances at the end of Cn.
  - Minimum latency is 2 cycles.
- Bus rules:
  - dmem_ready is sampled only while dmem_req is high.
  - A request is never withdrawn before dmem_ready is seen, except on timeout or reset.
- Timeout: dmem_req stays high for exactly TIMEOUT_CYCLES cycles. Its last cycle has mem_stall low, and wb_exc=10 follows on the next cycle.
- Back-to-back: a new op presented in the cycle after completion is accepted normally from IDLE.

## Test plan
- Single-cycle retire: ADD with ex_alu_result=0x1234, rd=5 -> the next cycle has wb_valid=1, wb_data=0x1234, wb_rd=5, and mem_stall never goes high.
- Store formatting:
  - SB, addr=0x103, rs2=0xAABBCCDD -> dmem_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD.
  - SH, addr=0x102 -> wstrb=1100, wdata=0xCCDDCCDD.
- Load sign/zero extension with dmem_rdata=0x80FF7F01 and ready on the first cycle:
  - LB at offset 3 -> wb_data=0xFFFFFF80.
  - LBU at offset 3 -> wb_data=0x00000080.
  - LH at offset 0 -> wb_data=0x00007F01.
  - In each case wb_valid is high 2 cycles after the op is presented.
- Wait states: LW with ready asserted in the 4th request cycle -> mem_stall high for 4 cycles; wb_valid on the 5th cycle after the op is presented, holding the rdata value.
- Exceptions:
  - LW at addr 0x102 -> wb_exc=01, dmem_req stays 0, wb_reg_write=0.
  - Load with funct3=011 -> wb_exc=11.
  - TIMEOUT_CYCLES=4 with ready never asserted -> dmem_req high exactly 4 cycles, then wb_exc=10.
- Reset during ACCESS: assert reset in the 2nd request cycle -> dmem_req and mem_stall drop immediately, no wb_valid follows, and the next op after reset is released behaves normally.
